// File: rtl/sd_block_responder_if.sv
// Bundles the sector-request side (sd_*) and the backing-store side (mem_*) of the block responder.
// slave is the responder's view; master is the initiator plus backing store.
interface sd_block_responder_if #(
    parameter int LBA_BITS = 7
);
    logic [31:0]         sd_lba;
    logic                sd_rd;
    logic                sd_wr;
    logic                sd_ack;
    logic [7:0]          sd_buff_addr;
    logic [15:0]         sd_buff_dout;
    logic                sd_buff_wr;
    logic [15:0]         sd_buff_din;
    logic [LBA_BITS+7:0] mem_addr;
    logic                mem_rd;
    logic                mem_wr;
    logic [15:0]         mem_dout;
    logic [15:0]         mem_din;
    logic                mem_ready;

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_dout
    );

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_dout
    );
endinterface

// File: rtl/sd_block_responder.sv
// Responder for 512-byte sector reads/writes over the sd_rd/sd_wr/sd_ack/sd_buff protocol,
// backed by a word-addressed store with a ready handshake.
module sd_block_responder #(
    parameter int LBA_BITS = 7,
    parameter int DIN_LAT  = 2
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    sd_block_responder_if.slave  bus,
    output logic                 busy,
    output logic                 err,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_PUSH,
        WR_ADDR,
        WR_WAIT,
        WR_MEM,
        FINISH
    } state_t;

    // DIN_LAT is expected to be at least 1.
    localparam logic [7:0] WAIT_LAST = 8'(DIN_LAT - 1);

    state_t              state;
    state_t              state_next;
    logic [LBA_BITS-1:0] lba;
    logic                oor;
    logic [7:0]          idx;
    logic [15:0]         rd_data;
    logic [15:0]         wr_data;
    logic [7:0]          wait_cnt;

    logic                accept;
    logic                load_rd;
    logic                load_wr;
    logic                idx_inc;
    logic                wait_inc;

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Out-of-range transfers complete each access immediately so timing matches a ready-tied store.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_rd    = 1'b0;
        load_wr    = 1'b0;
        idx_inc    = 1'b0;
        wait_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sd_rd) begin
                    accept     = 1'b1;
                    state_next = RD_MEM;
                end else if (bus.sd_wr) begin
                    accept     = 1'b1;
                    state_next = WR_ADDR;
                end
            end
            RD_MEM: begin
                if (oor || bus.mem_ready) begin
                    load_rd    = 1'b1;
                    state_next = RD_PUSH;
                end
            end
            RD_PUSH: begin
                if (idx == 8'hFF) begin
                    state_next = FINISH;
                end else begin
                    idx_inc    = 1'b1;
                    state_next = RD_MEM;
                end
            end
            WR_ADDR: begin
                state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    load_wr    = 1'b1;
                    state_next = WR_MEM;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            WR_MEM: begin
                if (oor || bus.mem_ready) begin
                    if (idx == 8'hFF) begin
                        state_next = FINISH;
                    end else begin
                        idx_inc    = 1'b1;
                        state_next = WR_ADDR;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            lba      <= '0;
            oor      <= 1'b0;
            idx      <= '0;
            rd_data  <= '0;
            wr_data  <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                lba <= bus.sd_lba[LBA_BITS-1:0];
                oor <= |bus.sd_lba[31:LBA_BITS];
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 8'd1;
            end
            if (load_rd) begin
                rd_data <= oor ? 16'h0000 : bus.mem_din;
            end
            if (state == WR_ADDR) begin
                wait_cnt <= '0;
            end else if (wait_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (load_wr && !oor) begin
                wr_data <= bus.sd_buff_din;
            end
        end
    end

    // idx doubles as the buffer address, so it naturally holds between transfers.
    assign bus.sd_ack       = (state != IDLE) && (state != FINISH);
    assign busy             = (state != IDLE) && (state != FINISH);
    assign bus.sd_buff_wr   = (state == RD_PUSH);
    assign bus.sd_buff_addr = idx;
    assign bus.sd_buff_dout = rd_data;
    assign bus.mem_addr     = {lba, idx};
    assign bus.mem_rd       = (state == RD_MEM) && !oor;
    assign bus.mem_wr       = (state == WR_MEM) && !oor;
    assign bus.mem_dout     = wr_data;
    assign done             = (state == FINISH);
    assign err              = (state == FINISH) && oor;

endmodule

// File: tb/tb_sd_block_responder.sv
// Bench for sd_block_responder: vector table of whole-sector transfers checked through
// read/write scoreboards, plus reset-abort, back-to-back request and chained-load sequences.
module tb_sd_block_responder;

    localparam int LBA_BITS = 7;
    localparam int DIN_LAT  = 2;
    localparam int AW       = LBA_BITS + 8;

    typedef struct {
        logic [31:0] lba;
        logic        rd;
        logic        wr;
        logic        rnd_ready;
        int          exp_pulses;
        int          exp_mem_ops;
        logic        exp_err;
        int          exp_ack;
    } vec_t;

    logic clk_sys;
    logic reset;
    logic busy;
    logic err;
    logic done;

    sd_block_responder_if #(.LBA_BITS(LBA_BITS)) bus ();

    sd_block_responder #(
        .LBA_BITS(LBA_BITS),
        .DIN_LAT (DIN_LAT)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus),
        .busy   (busy),
        .err    (err),
        .done   (done)
    );

    logic [15:0] store [0:(1<<AW)-1];
    logic [15:0] model [0:(1<<AW)-1];

    assign bus.mem_din = store[bus.mem_addr];

    logic [23:0]      read_q  [$];
    logic [AW+15:0]   write_q [$];

    int n_compared;
    int n_mismatched;
    int ack_cycles;
    int busy_cycles;
    int busy_low;
    int done_cnt;
    int err_cnt;
    int pulses;
    int mem_ops;
    int strobe_cycles;

    logic           ready_random;
    logic           cur_write;
    logic           cur_oor;
    logic           ready_seen;
    logic           prev_pending;
    logic           prev_ready;
    logic [AW+17:0] prev_sig;
    logic [7:0]     last_addr;
    logic [15:0]    din_st1;

    vec_t vecs [10];

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endfunction

    function automatic void clear_counts();
        ack_cycles    = 0;
        busy_cycles   = 0;
        done_cnt      = 0;
        err_cnt       = 0;
        pulses        = 0;
        mem_ops       = 0;
        strobe_cycles = 0;
    endfunction

    // Everything the DUT shows in one cycle, sampled mid-cycle.
    function automatic void monitor();
        logic [AW+17:0] cur_sig;
        logic [23:0]    rexp;
        logic [AW+15:0] wexp;
        last_addr = bus.sd_buff_addr;
        if (bus.sd_ack) ack_cycles++;
        if (busy) busy_cycles++;
        else busy_low++;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            checkOutput("err_with_done", 64'(done), 64'd1);
        end
        if (bus.mem_rd || bus.mem_wr) strobe_cycles++;
        cur_sig = {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_dout};
        if (prev_pending && !prev_ready) checkOutput("mem_hold", 64'(cur_sig), 64'(prev_sig));
        prev_pending = bus.mem_rd || bus.mem_wr;
        prev_ready   = bus.mem_ready;
        prev_sig     = cur_sig;
        if (bus.mem_rd && bus.mem_ready) begin
            mem_ops++;
            ready_seen = 1'b1;
        end
        if (bus.mem_wr && bus.mem_ready) begin
            mem_ops++;
            checkOutput("wr_sb_nonempty", 64'(write_q.size() != 0), 64'd1);
            if (write_q.size() != 0) begin
                wexp = write_q.pop_front();
                checkOutput("mem_write", 64'({bus.mem_addr, bus.mem_dout}), 64'(wexp));
            end
            store[bus.mem_addr] = bus.mem_dout;
        end
        if (bus.sd_buff_wr) begin
            pulses++;
            checkOutput("bwr_ack", 64'(bus.sd_ack), 64'd1);
            checkOutput("bwr_dir", 64'(cur_write), 64'd0);
            if (!cur_oor) checkOutput("bwr_after_ready", 64'(ready_seen), 64'd1);
            ready_seen = 1'b0;
            checkOutput("rd_sb_nonempty", 64'(read_q.size() != 0), 64'd1);
            if (read_q.size() != 0) begin
                rexp = read_q.pop_front();
                checkOutput("read_word", 64'({bus.sd_buff_addr, bus.sd_buff_dout}), 64'(rexp));
            end
        end
    endfunction

    // Initiator RAM has two register stages: din follows ~addr two cycles late.
    task automatic step();
        @(posedge clk_sys);
        #1;
        bus.sd_buff_din = din_st1;
        din_st1         = ~{8'h00, last_addr};
        bus.mem_ready   = ready_random ? ($urandom_range(0, 9) < 3) : 1'b1;
        @(negedge clk_sys);
        monitor();
    endtask

    task automatic applyStimulus(input vec_t v, input int exp_lat);
        logic [AW-1:0] a;
        int            lat;
        int            n;
        clear_counts();
        ready_random = v.rnd_ready;
        cur_write    = v.wr && !v.rd;
        cur_oor      = |v.lba[31:LBA_BITS];
        ready_seen   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            a = {v.lba[LBA_BITS-1:0], 8'(i)};
            if (!cur_write) begin
                read_q.push_back({8'(i), cur_oor ? 16'h0000 : model[a]});
            end else if (!cur_oor) begin
                write_q.push_back({a, ~16'(i)});
                model[a] = ~16'(i);
            end
        end
        bus.sd_lba = v.lba;
        bus.sd_rd  = v.rd;
        bus.sd_wr  = v.wr;
        lat = 0;
        while (!bus.sd_ack && lat < 10) begin
            step();
            lat++;
        end
        checkOutput("ack_latency", 64'(lat), 64'(exp_lat));
        bus.sd_rd  = 1'b0;
        bus.sd_wr  = 1'b0;
        bus.sd_lba = 32'hFFFF_FF00;
        n = 0;
        while (done_cnt == 0 && n < 8000) begin
            step();
            n++;
        end
        checkOutput("done_seen", 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic verify_transfer(input vec_t v);
        checkOutput("done_count", 64'(done_cnt), 64'd1);
        checkOutput("err_count", 64'(err_cnt), 64'(v.exp_err));
        checkOutput("bwr_pulses", 64'(pulses), 64'(v.exp_pulses));
        checkOutput("mem_ops", 64'(mem_ops), 64'(v.exp_mem_ops));
        if (v.exp_mem_ops == 0) checkOutput("oor_strobes", 64'(strobe_cycles), 64'd0);
        if (v.exp_ack != 0) begin
            checkOutput("ack_cycles", 64'(ack_cycles), 64'(v.exp_ack));
            checkOutput("busy_cycles", 64'(busy_cycles), 64'(v.exp_ack));
        end
        checkOutput("rd_sb_drained", 64'(read_q.size()), 64'd0);
        checkOutput("wr_sb_drained", 64'(write_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.sd_ack, bus.sd_buff_addr, bus.sd_buff_dout, bus.sd_buff_wr,
                    bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.mem_dout, busy, err, done});
    endfunction

    initial begin
        vec_t cv;
        int   n;
        //          lba            rd    wr    rnd   pulses ops  err   ack
        vecs[0] = '{32'd3,         1'b1, 1'b0, 1'b0, 256,   256, 1'b0, 512};
        vecs[1] = '{32'd5,         1'b0, 1'b1, 1'b0, 0,     256, 1'b0, 1024};
        vecs[2] = '{32'd5,         1'b1, 1'b0, 1'b1, 256,   256, 1'b0, 0};
        vecs[3] = '{32'd128,       1'b1, 1'b0, 1'b0, 256,   0,   1'b1, 512};
        vecs[4] = '{32'd128,       1'b0, 1'b1, 1'b0, 0,     0,   1'b1, 1024};
        vecs[5] = '{32'd7,         1'b1, 1'b1, 1'b0, 256,   256, 1'b0, 512};
        vecs[6] = '{32'd127,       1'b1, 1'b0, 1'b1, 256,   256, 1'b0, 0};
        vecs[7] = '{32'h8000_0003, 1'b0, 1'b1, 1'b1, 0,     0,   1'b1, 1024};
        vecs[8] = '{32'h42,        1'b0, 1'b1, 1'b1, 0,     256, 1'b0, 0};
        vecs[9] = '{32'h42,        1'b1, 1'b0, 1'b0, 256,   256, 1'b0, 512};

        n_compared   = 0;
        n_mismatched = 0;
        busy_low     = 0;
        clear_counts();
        for (int a = 0; a < (1 << AW); a++) begin
            store[a] = 16'(a);
            model[a] = 16'(a);
        end
        ready_random    = 1'b0;
        cur_write       = 1'b0;
        cur_oor         = 1'b0;
        ready_seen      = 1'b0;
        prev_pending    = 1'b0;
        prev_ready      = 1'b1;
        prev_sig        = '0;
        last_addr       = '0;
        din_st1         = '0;
        reset           = 1'b0;
        bus.sd_lba      = '0;
        bus.sd_rd       = 1'b0;
        bus.sd_wr       = 1'b0;
        bus.sd_buff_din = '0;
        bus.mem_ready   = 1'b1;

        $display("[TB] reset state");
        repeat (3) step();
        checkOutput("reset_outputs", all_outputs(), 64'd0);
        reset = 1'b1;
        step();

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            step();
            applyStimulus(vecs[i], 1);
            verify_transfer(vecs[i]);
        end

        $display("[TB] request already high during FINISH");
        applyStimulus(vecs[0], 2);
        verify_transfer(vecs[0]);

        $display("[TB] reset during a read");
        step();
        clear_counts();
        ready_random = 1'b0;
        cur_write    = 1'b0;
        cur_oor      = 1'b0;
        ready_seen   = 1'b0;
        for (int i = 0; i < 256; i++) read_q.push_back({8'(i), model[{7'd9, 8'(i)}]});
        bus.sd_lba = 32'd9;
        bus.sd_rd  = 1'b1;
        n = 0;
        while (!bus.sd_ack && n < 10) begin
            step();
            n++;
        end
        bus.sd_rd = 1'b0;
        n = 0;
        while (!(bus.sd_buff_wr && bus.sd_buff_addr == 8'd100) && n < 1000) begin
            step();
            n++;
        end
        checkOutput("reached_word_100", 64'(bus.sd_buff_addr), 64'd100);
        reset = 1'b0;
        read_q.delete();
        prev_pending = 1'b0;
        step();
        checkOutput("abort_outputs", all_outputs(), 64'd0);
        reset = 1'b1;
        clear_counts();
        repeat (20) step();
        checkOutput("post_abort_pulses", 64'(pulses), 64'd0);
        checkOutput("post_abort_strobes", 64'(strobe_cycles), 64'd0);
        checkOutput("post_abort_ack", 64'(ack_cycles), 64'd0);
        applyStimulus(vecs[0], 1);
        verify_transfer(vecs[0]);

        $display("[TB] chained 128-sector load");
        step();
        busy_low = 0;
        for (int s = 0; s < 128; s++) begin
            cv = '{32'(s), 1'b1, 1'b0, 1'b0, 256, 256, 1'b0, 512};
            applyStimulus(cv, 1);
            verify_transfer(cv);
            if (s != 127) step();
        end
        checkOutput("chain_busy_low", 64'(busy_low), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sd_block_responder.md
Name: sd_block_responder

Overview:
Responder end of the sd_rd/sd_wr/sd_ack/sd_buff block protocol used by the backup-RAM save/load sequencer. It services 512-byte sector requests (256 16-bit words) against a word-addressed backing store with a ready handshake. It stands in for the HPS side in simulation and in standalone save-store builds.

Parameters:
LBA_BITS, 7, number of valid sector-index bits; capacity is 2^LBA_BITS sectors.
DIN_LAT, 2, cycles from driving sd_buff_addr to sampling sd_buff_din (initiator's registered-RAM read latency).

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-low
sd_lba  in  32  sector index from initiator
sd_rd  in  1  read request (level)
sd_wr  in  1  write request (level)
sd_ack  out  1  transfer in progress
sd_buff_addr  out  8  word index within sector
sd_buff_dout  out  16  read data to initiator
sd_buff_wr  out  1  read-data strobe
sd_buff_din  in  16  write data from initiator
mem_addr  out  LBA_BITS+8  backing-store word address {lba,idx}
mem_rd  out  1  backing-store read request
mem_wr  out  1  backing-store write request
mem_dout  out  16  backing-store write data
mem_din  in  16  backing-store read data, valid with mem_ready
mem_ready  in  1  completes the pending mem_rd/mem_wr in the same cycle
busy  out  1  high from acceptance until ack drops
err  out  1  one-cycle pulse at end of out-of-range transfer
done  out  1  one-cycle pulse at end of every transfer

Behaviour:
- Reset (reset=0 at clk edge): every output is 0, state IDLE; an in-flight transfer is abandoned, with no further sd_buff_wr or mem strobes.
- States: IDLE, RD_MEM, RD_PUSH, WR_ADDR, WR_WAIT, WR_MEM, FINISH.
- IDLE: sample sd_rd/sd_wr. If either is high, latch sd_lba and direction, idx=0, and set sd_ack=1 and busy=1 the next cycle. sd_rd takes priority when both are high. Requests are level-sensitive; the initiator drops them after seeing the ack rise.
- Range: oor = |sd_lba[31:LBA_BITS]. When oor is set, the transfer runs with identical timing, but mem_rd/mem_wr are never asserted, read words are 16'h0000, and write data is discarded.
- mem handshake: mem_rd/mem_wr and mem_addr/mem_dout stay stable until a cycle where mem_ready=1. That cycle completes the access, and the strobe drops the next cycle. mem_ready without a pending strobe is ignored.
- Read: RD_MEM drives mem_rd with mem_addr={lba[LBA_BITS-1:0],idx} and captures mem_din on mem_ready. RD_PUSH then asserts sd_buff_wr for exactly one cycle with sd_buff_addr=idx and sd_buff_dout=captured data. If idx==255 go to FINISH; otherwise increment idx and return to RD_MEM. With mem_ready tied high, a word takes 2 cycles.
- Write: WR_ADDR drives sd_buff_addr=idx. WR_WAIT holds it for DIN_LAT cycles, then latches sd_buff_din into mem_dout. WR_MEM drives mem_wr until mem_ready. Then either idx++ and return to WR_ADDR, or go to FINISH after idx 255.
- sd_buff_wr is never high while sd_ack is 0, and never high during a write transfer.
- FINISH: sd_ack=0 and busy=0, done=1 for one cycle, err=1 if oor; return to IDLE. A request already high in that FINISH cycle is accepted from IDLE on the following cycle.
- idx is 8 bits and does not wrap past 255 within a transfer. sd_buff_addr holds its last value between transfers.
- sd_lba changes during a transfer are ignored.

Test Plan:
- Read LBA 3, LBA_BITS=7, mem_ready=1, mem word = {lba,idx} pattern → sd_ack high 1 cycle after sd_rd; exactly 256 sd_buff_wr pulses with addr 0..255 ascending and dout 16'h0300..16'h03FF; done pulse; ack low.
- Write LBA 5, initiator RAM word i = ~i, DIN_LAT=2 → 256 mem_wr completions at addrs 0x500..0x5FF with data ~i; zero sd_buff_wr pulses.
- Read with mem_ready random (~30% duty) → same data and order; strobes held stable until ready; no sd_buff_wr without a preceding mem_ready.
- sd_lba=128 read and write → no mem strobes, reads return 0x0000, err and done pulse together, ack timing matches the in-range case.
- sd_rd and sd_wr both high → read performed; reset low at word 100 → all outputs 0 next cycle and no further strobes; a new request after reset completes normally.
- Chained 128-sector load where the initiator raises sd_rd the cycle after ack falls → all sectors transferred, no request lost, busy low only in the FINISH/IDLE gaps.
